// File: rtl/celement_pkg.sv
// Shared types for the clocked C-element fork FIFO: FSM encodings, default
// geometry, a buffer entry layout and a constant clog2 helper.
package celement_pkg;

  localparam int W_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT = 4;
  localparam int NCH_DEFAULT   = 2;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_REQ  = 2'd1,
    CH_RTZ  = 2'd2,
    CH_DONE = 2'd3
  } ch_state_e;

  // Buffer entry at the default geometry; the top builds a width-matched copy.
  typedef struct packed {
    logic [NCH_DEFAULT-1:0] mask;
    logic [W_DEFAULT-1:0]   data;
  } entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/celement_chan_hs.sv
// One output channel's 4-phase handshake: request, return-to-zero, then wait
// in DONE until every channel of the current token has finished.
module celement_chan_hs
  import celement_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic launch_i,
  input  logic sel_i,
  input  logic retire_i,
  input  logic ack_i,
  output logic send_o,
  output logic idle_o,
  output logic done_o
);

  ch_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= CH_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE: if (launch_i) state_d = sel_i ? CH_REQ : CH_DONE;
      CH_REQ:  if (ack_i)    state_d = CH_RTZ;
      CH_RTZ:  if (!ack_i)   state_d = CH_DONE;
      CH_DONE: if (retire_i) state_d = CH_IDLE;
      default:               state_d = CH_IDLE;
    endcase
  end

  assign send_o = (state_q == CH_REQ);
  assign idle_o = (state_q == CH_IDLE);
  assign done_o = (state_q == CH_DONE);

endmodule

// File: rtl/celement_fork_fifo.sv
// Token buffer with a 4-phase input port that forks each head token to the
// output channels selected by its mask; an all-zero mask drops the token.
module celement_fork_fifo
  import celement_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int NCH   = NCH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  LOPEN,
  input  logic                  SENDIN,
  input  logic [NCH-1:0]        EXBIN,
  input  logic [W-1:0]          DATAIN,
  output logic                  ACKOUT,
  output logic [NCH-1:0]        SENDOUT,
  output logic [W-1:0]          DATAOUT,
  input  logic [NCH-1:0]        ACKIN,
  output logic                  CP,
  output logic [clog2(DEPTH):0] COUNT
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [NCH-1:0] mask;
    logic [W-1:0]   data;
  } fifo_entry_t;

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  in_state_e     in_state_q, in_state_d;
  logic          cp_q;

  logic          push, pop, full, head_valid;
  logic          start_ok, launch, drop_pop, retire_pop;
  logic [NCH-1:0] chan_idle, chan_done;

  assign full       = (count_q == CW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  // Input side: a full buffer leaves SENDIN pending even on a popping edge.
  always_comb begin
    in_state_d = in_state_q;
    push       = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (SENDIN && !full) begin
          push       = 1'b1;
          in_state_d = IN_ACK;
        end
      end
      IN_ACK:  if (!SENDIN) in_state_d = IN_IDLE;
      default: in_state_d = IN_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {EXBIN, DATAIN};
  end

  // A new token only starts once every channel has returned to idle.
  assign start_ok   = head_valid && LOPEN && (&chan_idle);
  assign launch     = start_ok && (|head.mask);
  assign drop_pop   = start_ok && !(|head.mask);
  assign retire_pop = &chan_done;
  assign pop        = drop_pop || retire_pop;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    celement_chan_hs u_chan (
      .clk_i    (CLK),
      .rst_ni   (RESETN),
      .launch_i (launch),
      .sel_i    (head.mask[gi]),
      .retire_i (retire_pop),
      .ack_i    (ACKIN[gi]),
      .send_o   (SENDOUT[gi]),
      .idle_o   (chan_idle[gi]),
      .done_o   (chan_done[gi])
    );
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      in_state_q <= IN_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cp_q       <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cp_q       <= pop;
    end
  end

  assign ACKOUT  = (in_state_q == IN_ACK);
  assign CP      = cp_q;
  assign COUNT   = count_q;
  assign DATAOUT = head_valid ? head.data : '0;

endmodule

// File: tb/tb_celement_fork_fifo.sv
// Directed bench for celement_fork_fifo: a queue-level token model checked every
// cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_celement_fork_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           lopen;
  logic           sendin;
  logic [NCH-1:0] exbin;
  logic [W-1:0]   datain;
  wire            ackout;
  wire  [NCH-1:0] sendout;
  wire  [W-1:0]   dataout;
  wire  [NCH-1:0] ackin;
  wire            cp;
  wire  [2:0]     count;

  always #5 clk = ~clk;

  celement_fork_fifo #(.W(W), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .CLK     (clk),
    .RESETN  (rst_n),
    .LOPEN   (lopen),
    .SENDIN  (sendin),
    .EXBIN   (exbin),
    .DATAIN  (datain),
    .ACKOUT  (ackout),
    .SENDOUT (sendout),
    .DATAOUT (dataout),
    .ACKIN   (ackin),
    .CP      (cp),
    .COUNT   (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  // Consumers: each channel acknowledges after resp_delay negedges, then returns to zero.
  int             resp_delay [NCH];
  logic [NCH-1:0] resp_en;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_resp
    logic a;
    int   cnt;
    assign ackin[gi] = a;
    initial begin
      a   = 1'b0;
      cnt = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          a   = 1'b0;
          cnt = 0;
        end else if (resp_en[gi]) begin
          if (sendout[gi] && !a) begin
            if (cnt >= resp_delay[gi]) begin
              a   = 1'b1;
              cnt = 0;
            end else cnt++;
          end else if (!sendout[gi] && a) a = 1'b0;
        end
      end
    end
  end

  // Token-level model: queue of buffered tokens, per-channel outstanding sets.
  typedef struct {
    logic [NCH-1:0] mask;
    logic [W-1:0]   data;
  } tok_t;

  tok_t           mq[$];
  bit             m_ack, m_cp, m_launched;
  logic [NCH-1:0] m_req, m_rtz;
  logic [W-1:0]   seen0[$];
  int             cp_total = 0;

  initial begin
    logic           s_rst, s_send, s_lopen, do_push, do_pop;
    logic [NCH-1:0] s_exb, s_ack, fired, exp_send, prev_send;
    logic [W-1:0]   s_data;
    tok_t           t;
    prev_send = '0;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_send = sendin; s_lopen = lopen;
      s_exb = exbin; s_data = datain; s_ack = ackin;
      if (s_rst !== 1'b1) begin
        mq.delete();
        m_ack = 0; m_cp = 0; m_launched = 0; m_req = '0; m_rtz = '0;
      end else begin
        do_push = !m_ack && s_send && (mq.size() < DEPTH);
        do_pop  = 1'b0;
        if (m_launched) begin
          if (m_req == '0 && m_rtz == '0) begin
            do_pop     = 1'b1;
            m_launched = 0;
          end else begin
            fired = m_req & s_ack;
            m_rtz = (m_rtz & s_ack) | fired;
            m_req = m_req & ~s_ack;
          end
        end else if (mq.size() > 0 && s_lopen) begin
          if (mq[0].mask == '0) do_pop = 1'b1;
          else begin
            m_launched = 1;
            m_req      = mq[0].mask;
            m_rtz      = '0;
          end
        end
        m_cp = do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          t.mask = s_exb;
          t.data = s_data;
          mq.push_back(t);
        end
        if (do_push) m_ack = 1;
        else if (m_ack && !s_send) m_ack = 0;
      end
      #1;
      exp_send = m_launched ? m_req : '0;
      chk("cyc_ackout", ackout, m_ack);
      chk("cyc_sendout", sendout, exp_send);
      chk("cyc_cp", cp, m_cp);
      chk("cyc_count", count, mq.size());
      if (mq.size() > 0) chk("cyc_dataout", dataout, mq[0].data);
      if (sendout[0] && !prev_send[0]) seen0.push_back(dataout);
      prev_send = sendout;
      if (cp === 1'b1) begin
        cp_total++;
        $display("retire #%0d at %0t count=%0d", cp_total, $time, count);
      end
    end
  end

  task automatic push_tok(input logic [NCH-1:0] m, input logic [W-1:0] d);
    int n;
    n = 0;
    while (ackout === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    sendin = 1'b1;
    exbin  = m;
    datain = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ackout !== 1'b1 && n < 60);
    if (ackout !== 1'b1) fail_to("push_ack");
    sendin = 1'b0;
    $display("push data=%02h mask=%b count=%0d", d, m, count);
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n;
    n = 0;
    while (count !== 3'd0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (count !== 3'd0) fail_to(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpn, t_first, t_cp, sends, n;
    rst_n = 1'b0; lopen = 1'b1; sendin = 1'b1; exbin = 2'b11; datain = 8'h5A;
    resp_en = '0; resp_delay[0] = 0; resp_delay[1] = 0;

    // Reset with SENDIN already high
    repeat (3) @(negedge clk);
    chk("rst_ackout", ackout, 0);
    chk("rst_sendout", sendout, 0);
    chk("rst_cp", cp, 0);
    chk("rst_count", count, 0);
    chk("rst_dataout", dataout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_ackout", ackout, 1);
    chk("first_count", count, 1);
    sendin  = 1'b0;
    resp_en = 2'b11;
    wait_empty("first_drain", 20);

    // Fork: channel 1 acknowledges three cycles after channel 0
    resp_delay[1] = 3;
    push_tok(2'b11, 8'hA5);
    cpn = 0; t_first = -1; t_cp = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sendout != '0) begin
        if (t_first < 0) t_first = c;
        chk("fork_dataout", dataout, 8'hA5);
      end
      if (cp) begin
        cpn++;
        if (t_cp < 0) t_cp = c;
      end
    end
    chk("fork_cp_once", cpn, 1);
    chk("fork_cp_latency", t_cp - t_first, 6);
    resp_delay[1] = 0;

    // Drop path
    push_tok(2'b00, 8'h33);
    chk("drop_count1", count, 1);
    chk("drop_cp_pre", cp, 0);
    @(negedge clk);
    chk("drop_count0", count, 0);
    chk("drop_cp", cp, 1);
    sends = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (sendout != '0) sends++;
    end
    chk("drop_no_sendout", sends, 0);

    // Full buffer and backpressure, ordering on channel 0
    resp_en = 2'b00;
    seen0.delete();
    for (int k = 1; k <= 4; k++) push_tok(2'b01, 8'(k));
    chk("full_count4", count, 4);
    repeat (2) @(negedge clk);
    sendin = 1'b1; exbin = 2'b01; datain = 8'h05;
    repeat (6) @(negedge clk);
    chk("full_hold_ack", ackout, 0);
    chk("full_hold_count", count, 4);
    resp_en[0] = 1'b1;
    n = 0;
    while (ackout !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (ackout !== 1'b1) fail_to("full_accept");
    else chk("full_accept_count", count, 4);
    sendin = 1'b0;
    wait_empty("full_drain", 80);
    chk("order_len", seen0.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("order_data", (k < seen0.size()) ? seen0[k] : 8'hFF, k + 1);
    resp_en = 2'b11;

    // LOPEN gating: blocks launch, never an in-flight request
    @(negedge clk);
    lopen = 1'b0;
    resp_delay[0] = 2;
    push_tok(2'b11, 8'h77);
    push_tok(2'b11, 8'h88);
    repeat (4) @(negedge clk);
    chk("lopen_block_send", sendout, 0);
    chk("lopen_block_count", count, 2);
    lopen = 1'b1;
    @(negedge clk);
    chk("lopen_launch", sendout, 2'b11);
    lopen = 1'b0;
    repeat (12) @(negedge clk);
    chk("lopen_count1", count, 1);
    chk("lopen_hold_send", sendout, 0);
    chk("lopen_head", dataout, 8'h88);
    lopen = 1'b1;
    wait_empty("lopen_drain", 20);
    resp_delay[0] = 0;
    lopen = 1'b0;
    push_tok(2'b00, 8'h44);
    repeat (3) @(negedge clk);
    chk("lopen_drop_wait", count, 1);
    lopen = 1'b1;
    @(negedge clk);
    chk("lopen_drop_go", count, 0);
    chk("lopen_drop_cp", cp, 1);

    // Reset in the middle of a handshake
    resp_en = 2'b00;
    push_tok(2'b01, 8'h11);
    push_tok(2'b01, 8'h22);
    push_tok(2'b01, 8'h33);
    chk("midrst_count3", count, 3);
    chk("midrst_send", sendout, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("midrst_sendout0", sendout, 0);
    chk("midrst_count0", count, 0);
    chk("midrst_ackout0", ackout, 0);
    chk("midrst_cp0", cp, 0);
    chk("midrst_dataout0", dataout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 2'b11;
    @(negedge clk);
    sendin = 1'b1; exbin = 2'b11; datain = 8'hC3;
    @(negedge clk);
    chk("post_rst_ackout", ackout, 1);
    chk("post_rst_count", count, 1);
    chk("post_rst_dataout", dataout, 8'hC3);
    sendin = 1'b0;
    wait_empty("post_rst_drain", 20);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
